// File: rtl/obi_atop_rmw_resolver_if.sv
// Flattened OBI request/response bundle shared by the upstream and downstream sides of the
// ATOP resolver; master drives the A channel, slave drives gnt and the R channel.
interface obi_atop_rmw_resolver_if #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned IdWidth   = 1
) ();
   logic                   req;
   logic                   gnt;
   logic [AddrWidth-1:0]   addr;
   logic                   we;
   logic [DataWidth/8-1:0] be;
   logic [DataWidth-1:0]   wdata;
   logic [IdWidth-1:0]     aid;
   logic [5:0]             atop;
   logic                   rvalid;
   logic [DataWidth-1:0]   rdata;
   logic [IdWidth-1:0]     rid;
   logic                   err;

   modport master (
      output req, addr, we, be, wdata, aid, atop,
      input  gnt, rvalid, rdata, rid, err
   );

   modport slave (
      input  req, addr, we, be, wdata, aid, atop,
      output gnt, rvalid, rdata, rid, err
   );
endinterface

// File: rtl/obi_atop_rmw_resolver.sv
// Resolves OBI atomics into downstream read / local ALU / downstream write; plain traffic passes.
// Define OBI_ATOP_LRSC_EN to add LR/SC with a single reservation register.
module obi_atop_rmw_resolver #(
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned IdWidth        = 1,
   parameter int unsigned MaxOutstanding = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   obi_atop_rmw_resolver_if.slave  sbr_port,
   obi_atop_rmw_resolver_if.master mgr_port
);
   localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

   localparam logic [5:0] AtopAdd  = 6'h20;
   localparam logic [5:0] AtopSwap = 6'h21;
   localparam logic [5:0] AtopXor  = 6'h24;
   localparam logic [5:0] AtopOr   = 6'h28;
   localparam logic [5:0] AtopAnd  = 6'h2C;
   localparam logic [5:0] AtopMin  = 6'h30;
   localparam logic [5:0] AtopMax  = 6'h34;
   localparam logic [5:0] AtopMinu = 6'h38;
   localparam logic [5:0] AtopMaxu = 6'h3C;
`ifdef OBI_ATOP_LRSC_EN
   localparam logic [5:0] AtopLr   = 6'h22;
   localparam logic [5:0] AtopSc   = 6'h23;
`endif

   if (DataWidth != 32) begin : g_width_check
      $error("obi_atop_rmw_resolver: DataWidth must be 32");
   end

   typedef enum logic [2:0] {StIdle, StRdReq, StRdWait, StWrReq, StWrWait, StResp} state_e;

   state_e                 r_state, w_state_d;
   logic [CntWidth-1:0]    r_cnt, w_cnt_d;
   logic [AddrWidth-1:0]   r_addr, w_addr_d;
   logic [DataWidth-1:0]   r_wdata, w_wdata_d;
   logic [DataWidth-1:0]   r_old, w_old_d;
   logic [IdWidth-1:0]     r_aid, w_aid_d;
   logic [5:0]             r_atop, w_atop_d;
   logic                   r_err, w_err_d;

   logic                   w_room, w_drained, w_cnt_inc, w_cnt_dec;
   logic [DataWidth-1:0]   w_alu;
   logic                   w_sbr_gnt, w_sbr_rvalid, w_sbr_err;
   logic [DataWidth-1:0]   w_sbr_rdata;
   logic [IdWidth-1:0]     w_sbr_rid;
   logic                   w_mgr_req, w_mgr_we;
   logic [AddrWidth-1:0]   w_mgr_addr;
   logic [DataWidth/8-1:0] w_mgr_be;
   logic [DataWidth-1:0]   w_mgr_wdata;
   logic [IdWidth-1:0]     w_mgr_aid;

`ifdef OBI_ATOP_LRSC_EN
   logic                   r_rsv_valid, w_rsv_valid_d;
   logic [AddrWidth-1:0]   r_rsv_addr, w_rsv_addr_d;
   logic                   w_rsv_hit;
   assign w_rsv_hit = r_rsv_valid && (r_rsv_addr == sbr_port.addr);
`endif

   function automatic logic is_alu_op(input logic [5:0] atop);
      return atop inside {AtopAdd, AtopSwap, AtopXor, AtopOr, AtopAnd,
                          AtopMin, AtopMax, AtopMinu, AtopMaxu};
   endfunction

   function automatic logic [DataWidth-1:0] alu(input logic [5:0] atop,
                                                input logic [DataWidth-1:0] a,
                                                input logic [DataWidth-1:0] b);
      case (atop)
         AtopAdd:  return a + b;
         AtopXor:  return a ^ b;
         AtopOr:   return a | b;
         AtopAnd:  return a & b;
         AtopMin:  return ($signed(a) < $signed(b)) ? a : b;
         AtopMax:  return ($signed(a) > $signed(b)) ? a : b;
         AtopMinu: return (a < b) ? a : b;
         AtopMaxu: return (a > b) ? a : b;
         default:  return b;  // SWAP, and SC stores its wdata unchanged
      endcase
   endfunction

   assign w_alu     = alu(r_atop, r_old, r_wdata);
   assign w_room    = r_cnt < CntWidth'(MaxOutstanding);
   // A passthrough response retiring the last outstanding beat lets an AMO win the same cycle.
   assign w_drained = (r_cnt == '0) || ((r_cnt == CntWidth'(1)) && mgr_port.rvalid);

   always_comb begin
      w_state_d    = r_state;
      w_addr_d     = r_addr;
      w_wdata_d    = r_wdata;
      w_old_d      = r_old;
      w_aid_d      = r_aid;
      w_atop_d     = r_atop;
      w_err_d      = r_err;
      w_sbr_gnt    = 1'b0;
      w_sbr_rvalid = 1'b0;
      w_sbr_rdata  = r_old;
      w_sbr_rid    = r_aid;
      w_sbr_err    = r_err;
      w_mgr_req    = 1'b0;
      w_mgr_addr   = r_addr;
      w_mgr_we     = 1'b0;
      w_mgr_be     = '1;
      w_mgr_wdata  = w_alu;
      w_mgr_aid    = r_aid;
      unique case (r_state)
         StIdle: begin
            w_sbr_rvalid = mgr_port.rvalid;
            w_sbr_rdata  = mgr_port.rdata;
            w_sbr_rid    = mgr_port.rid;
            w_sbr_err    = mgr_port.err;
            if (sbr_port.req && (sbr_port.atop == '0)) begin
               w_mgr_req   = w_room;
               w_mgr_addr  = sbr_port.addr;
               w_mgr_we    = sbr_port.we;
               w_mgr_be    = sbr_port.be;
               w_mgr_wdata = sbr_port.wdata;
               w_mgr_aid   = sbr_port.aid;
               w_sbr_gnt   = mgr_port.gnt && w_room;
            end else if (sbr_port.req && w_drained) begin
               w_sbr_gnt = 1'b1;
               w_addr_d  = sbr_port.addr;
               w_wdata_d = sbr_port.wdata;
               w_aid_d   = sbr_port.aid;
               w_atop_d  = sbr_port.atop;
               w_old_d   = '0;
               w_err_d   = 1'b0;
               if (is_alu_op(sbr_port.atop)) begin
                  w_state_d = StRdReq;
`ifdef OBI_ATOP_LRSC_EN
               end else if (sbr_port.atop == AtopLr) begin
                  w_state_d = StRdReq;
               end else if (sbr_port.atop == AtopSc) begin
                  if (w_rsv_hit) begin
                     w_state_d = StWrReq;
                  end else begin
                     w_old_d   = DataWidth'(1);
                     w_state_d = StResp;
                  end
`endif
               end else begin
                  w_err_d   = 1'b1;
                  w_state_d = StResp;
               end
            end
         end
         StRdReq: begin
            w_mgr_req = 1'b1;
            if (mgr_port.gnt) w_state_d = StRdWait;
         end
         StRdWait: begin
            if (mgr_port.rvalid) begin
               w_old_d = mgr_port.rdata;
               w_err_d = mgr_port.err;
               if (mgr_port.err) begin
                  w_state_d = StResp;
`ifdef OBI_ATOP_LRSC_EN
               end else if (r_atop == AtopLr) begin
                  w_state_d = StResp;
`endif
               end else begin
                  w_state_d = StWrReq;
               end
            end
         end
         StWrReq: begin
            w_mgr_req = 1'b1;
            w_mgr_we  = 1'b1;
            if (mgr_port.gnt) w_state_d = StWrWait;
         end
         StWrWait: begin
            if (mgr_port.rvalid) begin
               w_sbr_rvalid = 1'b1;
               w_sbr_err    = r_err | mgr_port.err;
               w_state_d    = StIdle;
            end
         end
         StResp: begin
            w_sbr_rvalid = 1'b1;
            w_state_d    = StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   // Only passthrough traffic is counted; AMOs run with the counter at zero.
   assign w_cnt_inc = (r_state == StIdle) && w_mgr_req && mgr_port.gnt;
   assign w_cnt_dec = (r_state == StIdle) && mgr_port.rvalid && (r_cnt != '0);

   always_comb begin
      w_cnt_d = r_cnt;
      case ({w_cnt_inc, w_cnt_dec})
         2'b10:   w_cnt_d = r_cnt + CntWidth'(1);
         2'b01:   w_cnt_d = r_cnt - CntWidth'(1);
         default: w_cnt_d = r_cnt;
      endcase
   end

`ifdef OBI_ATOP_LRSC_EN
   always_comb begin
      w_rsv_valid_d = r_rsv_valid;
      w_rsv_addr_d  = r_rsv_addr;
      if ((r_state == StRdWait) && mgr_port.rvalid && !mgr_port.err && (r_atop == AtopLr)) begin
         w_rsv_valid_d = 1'b1;
         w_rsv_addr_d  = r_addr;
      end
      if ((r_state == StIdle) && w_sbr_gnt && (sbr_port.atop == AtopSc)) w_rsv_valid_d = 1'b0;
      if (w_mgr_req && mgr_port.gnt && w_mgr_we && (w_mgr_addr == r_rsv_addr)) begin
         w_rsv_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rsv_valid <= 1'b0;
         r_rsv_addr  <= '0;
      end else begin
         r_rsv_valid <= w_rsv_valid_d;
         r_rsv_addr  <= w_rsv_addr_d;
      end
   end
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_old   <= '0;
         r_aid   <= '0;
         r_atop  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_addr  <= w_addr_d;
         r_wdata <= w_wdata_d;
         r_old   <= w_old_d;
         r_aid   <= w_aid_d;
         r_atop  <= w_atop_d;
         r_err   <= w_err_d;
      end
   end

   // Handshake outputs are held low for the whole reset pulse, not just after the next edge.
   assign sbr_port.gnt    = w_sbr_gnt & rst_ni;
   assign sbr_port.rvalid = w_sbr_rvalid & rst_ni;
   assign sbr_port.rdata  = w_sbr_rdata;
   assign sbr_port.rid    = w_sbr_rid;
   assign sbr_port.err    = w_sbr_err;

   assign mgr_port.req    = w_mgr_req & rst_ni;
   assign mgr_port.addr   = w_mgr_addr;
   assign mgr_port.we     = w_mgr_we;
   assign mgr_port.be     = w_mgr_be;
   assign mgr_port.wdata  = w_mgr_wdata;
   assign mgr_port.aid    = w_mgr_aid;
   assign mgr_port.atop   = '0;
endmodule

// File: tb/tb_obi_atop_rmw_resolver.sv
// Directed bench for obi_atop_rmw_resolver: memory model downstream, response scoreboard upstream.
module tb_obi_atop_rmw_resolver;
   localparam int unsigned IdW = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   obi_atop_rmw_resolver_if #(.AddrWidth(32), .DataWidth(32), .IdWidth(IdW)) sbr_if ();
   obi_atop_rmw_resolver_if #(.AddrWidth(32), .DataWidth(32), .IdWidth(IdW)) mgr_if ();

   obi_atop_rmw_resolver #(
      .AddrWidth(32), .DataWidth(32), .IdWidth(IdW), .MaxOutstanding(4)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .sbr_port(sbr_if), .mgr_port(mgr_if)
   );

   typedef struct packed {
      logic [31:0]    rdata;
      logic           err;
      logic [IdW-1:0] rid;
   } rsp_t;

   // Downstream memory: grants at once, answers in order one cycle later unless held.
   logic [31:0] mem [256];
   rsp_t        fifo [8];
   logic [2:0]  wp, rp;
   rsp_t        m_out;
   logic        m_rvalid;
   logic        hold   = 1'b0;
   logic        rd_err = 1'b0;
   int          n_hs   = 0;
   int          n_wr   = 0;
   logic        push;
   logic [7:0]  idx;
   logic [31:0] w_merged;
   rsp_t        w_new;

   assign mgr_if.gnt    = mgr_if.req;
   assign push          = mgr_if.req & mgr_if.gnt;
   assign idx           = mgr_if.addr[9:2];
   assign mgr_if.rvalid = m_rvalid;
   assign mgr_if.rdata  = m_out.rdata;
   assign mgr_if.err    = m_out.err;
   assign mgr_if.rid    = m_out.rid;

   always_comb begin
      w_merged = mem[idx];
      for (int b = 0; b < 4; b++) if (mgr_if.be[b]) w_merged[8*b +: 8] = mgr_if.wdata[8*b +: 8];
      w_new.rdata = mgr_if.we ? 32'h0 : mem[idx];
      w_new.err   = rd_err & ~mgr_if.we;
      w_new.rid   = mgr_if.aid;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp       <= '0;
         rp       <= '0;
         m_rvalid <= 1'b0;
         m_out    <= '0;
      end else begin
         m_rvalid <= 1'b0;
         if (push) begin
            n_hs <= n_hs + 1;
            if (mgr_if.we) begin
               mem[idx] <= w_merged;
               n_wr     <= n_wr + 1;
            end
         end
         if (!hold && (wp != rp)) begin
            m_out    <= fifo[rp];
            m_rvalid <= 1'b1;
            rp       <= rp + 3'd1;
            if (push) begin
               fifo[wp] <= w_new;
               wp       <= wp + 3'd1;
            end
         end else if (!hold && push) begin
            m_out    <= w_new;
            m_rvalid <= 1'b1;
         end else if (push) begin
            fifo[wp] <= w_new;
            wp       <= wp + 3'd1;
         end
      end
   end

   rsp_t exp_q [$];
   int   n_chk   = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   n_rv    = 0;
   int   last_rv = 0;
   logic gnt_s, mreq_s;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One clock: sample at the falling edge, return just after the rising edge.
   task automatic cycle();
      rsp_t e;
      @(negedge clk);
      cyc++;
      gnt_s  = sbr_if.gnt;
      mreq_s = mgr_if.req;
      if (sbr_if.rvalid) begin
         n_rv++;
         last_rv = cyc;
         n_chk++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_rvalid: observed rdata 0x%08h expected no response",
                   sbr_if.rdata);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rsp_rdata", sbr_if.rdata, e.rdata);
            chk("rsp_err", 32'(sbr_if.err), 32'(e.err));
            chk("rsp_rid", 32'(sbr_if.rid), 32'(e.rid));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic we, input logic [31:0] wd,
                        input logic [5:0] at, input logic [IdW-1:0] id,
                        input logic [31:0] er, input logic ee);
      rsp_t e;
      sbr_if.req   = 1'b1;
      sbr_if.addr  = a;
      sbr_if.we    = we;
      sbr_if.be    = 4'hF;
      sbr_if.wdata = wd;
      sbr_if.atop  = at;
      sbr_if.aid   = id;
      e.rdata = er;
      e.err   = ee;
      e.rid   = id;
      exp_q.push_back(e);
   endtask

   task automatic wait_gnt(input int budget, output int gcyc);
      logic got = 1'b0;
      gcyc = 0;
      for (int i = 0; i < budget; i++) begin
         cycle();
         if (gnt_s) begin
            got  = 1'b1;
            gcyc = cyc;
            break;
         end
      end
      chk("gnt_within_budget", 32'(got), 32'h1);
      sbr_if.req  = 1'b0;
      sbr_if.atop = '0;
   endtask

   task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] wd,
                        input logic [5:0] at, input logic [IdW-1:0] id,
                        input logic [31:0] er, input logic ee, output int gcyc);
      drive(a, we, wd, at, id, er, ee);
      wait_gnt(20, gcyc);
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) cycle();
      chk("responses_drained", 32'(exp_q.size()), 32'h0);
   endtask

   logic [5:0]  tab_at [8] = '{6'h24, 6'h2C, 6'h28, 6'h34, 6'h3C, 6'h30, 6'h20, 6'h21};
   logic [31:0] tab_wd [8] = '{32'h00FF00FF, 32'hF0F0F0F0, 32'h00000F00, 32'h80000000,
                               32'h80000000, 32'h00000001, 32'h80000001, 32'h00001234};
   logic [31:0] tab_old [8] = '{32'h0F0F0000, 32'h0FF000FF, 32'h00F000F0, 32'h00F00FF0,
                                32'h00F00FF0, 32'h80000000, 32'h80000000, 32'h00000001};

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int g, base, w0, h0;
      sbr_if.req   = 1'b1;
      sbr_if.addr  = 32'h100;
      sbr_if.we    = 1'b0;
      sbr_if.be    = 4'hF;
      sbr_if.wdata = '0;
      sbr_if.aid   = '0;
      sbr_if.atop  = '0;
      #1;
      chk("reset_mgr_req", 32'(mgr_if.req), 32'h0);
      chk("reset_sbr_gnt", 32'(sbr_if.gnt), 32'h0);
      chk("reset_sbr_rvalid", 32'(sbr_if.rvalid), 32'h0);
      sbr_if.req = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // AMOADD with minimum-latency check
      issue(32'h100, 1'b1, 32'd5, 6'h00, 4'd1, 32'h0, 1'b0, g);
      wait_idle(20);
      issue(32'h100, 1'b0, 32'd3, 6'h20, 4'd2, 32'd5, 1'b0, g);
      wait_idle(20);
      chk("amo_latency", 32'(last_rv - g), 32'd4);
      issue(32'h100, 1'b0, 32'd0, 6'h00, 4'd3, 32'd8, 1'b0, g);
      wait_idle(20);

      // Signed vs unsigned min on an all-ones word
      issue(32'h104, 1'b1, 32'hFFFFFFFF, 6'h00, 4'd4, 32'h0, 1'b0, g);
      issue(32'h104, 1'b0, 32'd1, 6'h30, 4'd5, 32'hFFFFFFFF, 1'b0, g);
      issue(32'h104, 1'b0, 32'd0, 6'h00, 4'd6, 32'hFFFFFFFF, 1'b0, g);
      issue(32'h104, 1'b0, 32'd1, 6'h38, 4'd7, 32'hFFFFFFFF, 1'b0, g);
      issue(32'h104, 1'b0, 32'd0, 6'h00, 4'd8, 32'h1, 1'b0, g);
      wait_idle(30);

      // Remaining ALU ops chained on one word
      issue(32'h108, 1'b1, 32'h0F0F0000, 6'h00, 4'd9, 32'h0, 1'b0, g);
      for (int i = 0; i < 8; i++) begin
         issue(32'h108, 1'b0, tab_wd[i], tab_at[i], IdW'(i), tab_old[i], 1'b0, g);
      end
      issue(32'h108, 1'b0, 32'd0, 6'h00, 4'd10, 32'h1234, 1'b0, g);
      wait_idle(40);

      // AMO waits for three outstanding reads to drain; order kept
      hold = 1'b1;
      base = n_rv;
      issue(32'h100, 1'b0, 32'd0, 6'h00, 4'd1, 32'd8, 1'b0, g);
      issue(32'h104, 1'b0, 32'd0, 6'h00, 4'd2, 32'd1, 1'b0, g);
      issue(32'h108, 1'b0, 32'd0, 6'h00, 4'd3, 32'h1234, 1'b0, g);
      drive(32'h100, 1'b0, 32'hAA, 6'h21, 4'd5, 32'd8, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("amo_gnt_held", 32'(gnt_s), 32'h0);
         chk("amo_mreq_held", 32'(mreq_s), 32'h0);
      end
      hold = 1'b0;
      wait_gnt(20, g);
      chk("amo_gnt_after_3_rvalid", 32'(n_rv - base), 32'd3);
      wait_idle(20);
      issue(32'h100, 1'b0, 32'd0, 6'h00, 4'd6, 32'hAA, 1'b0, g);
      wait_idle(20);

      // Outstanding limit of four
      hold = 1'b1;
      for (int i = 0; i < 4; i++) issue(32'h104, 1'b0, 32'd0, 6'h00, IdW'(i), 32'd1, 1'b0, g);
      drive(32'h108, 1'b0, 32'd0, 6'h00, 4'd7, 32'h1234, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("limit_gnt_held", 32'(gnt_s), 32'h0);
         chk("limit_mreq_held", 32'(mreq_s), 32'h0);
      end
      hold = 1'b0;
      wait_gnt(20, g);
      wait_idle(20);

      // Unsupported atop and read error
      h0 = n_hs;
      issue(32'h100, 1'b0, 32'd7, 6'h3F, 4'd2, 32'h0, 1'b1, g);
      wait_idle(10);
      chk("bad_atop_latency", 32'(last_rv - g), 32'd1);
      chk("bad_atop_no_access", 32'(n_hs - h0), 32'h0);
      rd_err = 1'b1;
      w0 = n_wr;
      issue(32'h104, 1'b0, 32'hFF, 6'h24, 4'd3, 32'd1, 1'b1, g);
      wait_idle(10);
      rd_err = 1'b0;
      chk("rd_err_no_write", 32'(n_wr - w0), 32'h0);
      issue(32'h104, 1'b0, 32'd0, 6'h00, 4'd4, 32'd1, 1'b0, g);
      wait_idle(10);

`ifdef OBI_ATOP_LRSC_EN
      issue(32'h200, 1'b1, 32'd7, 6'h00, 4'd1, 32'h0, 1'b0, g);
      issue(32'h200, 1'b0, 32'd0, 6'h22, 4'd2, 32'd7, 1'b0, g);
      wait_idle(10);
      w0 = n_wr;
      issue(32'h200, 1'b0, 32'd9, 6'h23, 4'd3, 32'd0, 1'b0, g);
      wait_idle(10);
      chk("sc_ok_written", 32'(n_wr - w0), 32'h1);
      issue(32'h200, 1'b0, 32'd0, 6'h00, 4'd4, 32'd9, 1'b0, g);
      issue(32'h200, 1'b0, 32'd0, 6'h22, 4'd5, 32'd9, 1'b0, g);
      issue(32'h200, 1'b1, 32'd11, 6'h00, 4'd6, 32'h0, 1'b0, g);
      wait_idle(10);
      w0 = n_wr;
      issue(32'h200, 1'b0, 32'd13, 6'h23, 4'd7, 32'd1, 1'b0, g);
      wait_idle(10);
      chk("sc_fail_no_write", 32'(n_wr - w0), 32'h0);
      issue(32'h200, 1'b0, 32'd0, 6'h00, 4'd8, 32'd11, 1'b0, g);
      wait_idle(10);
`else
      h0 = n_hs;
      issue(32'h200, 1'b0, 32'd0, 6'h22, 4'd1, 32'h0, 1'b1, g);
      issue(32'h200, 1'b0, 32'd9, 6'h23, 4'd2, 32'h0, 1'b1, g);
      wait_idle(10);
      chk("lrsc_off_no_access", 32'(n_hs - h0), 32'h0);
`endif

      // Reset in WR_REQ drops the AMO
      issue(32'h100, 1'b0, 32'd1, 6'h20, 4'd9, 32'hAA, 1'b0, g);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk("pre_reset_in_wr_req", 32'(mgr_if.req & mgr_if.we), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("midrst_mgr_req", 32'(mgr_if.req), 32'h0);
      chk("midrst_sbr_gnt", 32'(sbr_if.gnt), 32'h0);
      chk("midrst_sbr_rvalid", 32'(sbr_if.rvalid), 32'h0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      base = n_rv;
      for (int i = 0; i < 5; i++) cycle();
      chk("no_stray_rvalid", 32'(n_rv - base), 32'h0);
      drive(32'h100, 1'b0, 32'd1, 6'h20, 4'd10, 32'hAA, 1'b0);
      wait_gnt(1, g);
      wait_idle(20);
      issue(32'h100, 1'b0, 32'd0, 6'h00, 4'd11, 32'hAB, 1'b0, g);
      wait_idle(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
